// File: rtl/dlock_pkg.sv
// -----------------------------------------------------------------------------
// dlock_pkg
// Shared definitions for the digital lock front end.
//   btn_state_t        : debounce FSM state encoding used by btn_cond
//   DLOCK_DEBOUNCE_DEF : default number of identical samples to accept a level
//   DLOCK_STUCK_DEF    : default debounced-high duration that flags a stuck key
// -----------------------------------------------------------------------------
package dlock_pkg;

  typedef enum logic [1:0] {
    LO_IDLE = 2'd0,
    LO_WAIT = 2'd1,
    HI_IDLE = 2'd2,
    HI_WAIT = 2'd3
  } btn_state_t;

  localparam int DLOCK_DEBOUNCE_DEF = 4;
  localparam int DLOCK_STUCK_DEF    = 1024;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// One-bit, two-flop synchronizer. Both flops update on the falling edge of clk
// so that it lines up with the rest of the lock logic.
// Ports:
//   clk   in  clock (falling-edge active)
//   clear in  synchronous active-low reset, forces both stages to 0
//   d     in  asynchronous input
//   q     out synchronized output (second stage)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(negedge clk) begin
    if (!clear) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/btn_cond.sv
// -----------------------------------------------------------------------------
// btn_cond
// Pushbutton conditioner feeding the lock's serial b_in. Synchronizes the raw
// button, debounces it with a four-state FSM and emits one-cycle press/release
// pulses. All flops update on the falling edge of clk.
// Parameters:
//   DEBOUNCE_CYCLES : identical synchronized samples needed to accept a level
//                     change (1..255)
//   STUCK_CYCLES    : debounced-high duration that flags a stuck button
// Ports:
//   clk           in  clock (falling-edge active)
//   clear         in  synchronous active-low reset
//   btn_raw       in  asynchronous raw button, 1 = pressed
//   b_out         out debounced level
//   press_pulse   out one-cycle pulse when b_out rises
//   release_pulse out one-cycle pulse when b_out falls
//   stuck         out stuck-button flag
// Build option:
//   BTN_COND_STUCK_EN : when defined, a button held high for STUCK_CYCLES edges
//                       forces b_out low and raises stuck until the button has
//                       been seen low for DEBOUNCE_CYCLES samples. When not
//                       defined, stuck is tied to 0.
// -----------------------------------------------------------------------------
module btn_cond
  import dlock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DLOCK_DEBOUNCE_DEF,
  parameter int STUCK_CYCLES    = DLOCK_STUCK_DEF
) (
  input  logic clk,
  input  logic clear,
  input  logic btn_raw,
  output logic b_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic stuck
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || STUCK_CYCLES < 1) begin : g_bad_cfg
    $error("btn_cond: DEBOUNCE_CYCLES or STUCK_CYCLES out of range");
  end

  logic s;

  sync_2ff u_sync (
    .clk   (clk),
    .clear (clear),
    .d     (btn_raw),
    .q     (s)
  );

  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             b_reg, b_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;
  logic             hold_low;

`ifdef BTN_COND_STUCK_EN
  localparam int SCNT_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STUCK_CYCLES - 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STUCK_CYCLES);

  logic              stuck_reg, stuck_next;
  logic [SCNT_W-1:0] stuck_cnt_reg, stuck_cnt_next;

  // While flagged stuck the FSM parks in LO_IDLE and the debounce counter
  // instead measures how long the button has been seen released.
  assign hold_low = stuck_reg;
  assign stuck    = stuck_reg;
`else
  assign hold_low = 1'b0;
  assign stuck    = 1'b0;
`endif

  always_ff @(negedge clk) begin
    if (!clear) begin
      state_reg     <= LO_IDLE;
      cnt_reg       <= '0;
      b_reg         <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
`ifdef BTN_COND_STUCK_EN
      stuck_reg     <= 1'b0;
      stuck_cnt_reg <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      b_reg         <= b_next;
      press_reg     <= press_next;
      release_reg   <= release_next;
`ifdef BTN_COND_STUCK_EN
      stuck_reg     <= stuck_next;
      stuck_cnt_reg <= stuck_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    b_next       = b_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
`ifdef BTN_COND_STUCK_EN
    stuck_next     = stuck_reg;
    stuck_cnt_next = '0;
`endif

    case (state_reg)
      LO_IDLE: begin
        if (hold_low) begin
          if (s) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
`ifdef BTN_COND_STUCK_EN
            stuck_next = 1'b0;
`endif
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end else if (s) begin
          // A single-sample debounce accepts on the first high sample.
          if (DEBOUNCE_CYCLES == 1) begin
            state_next = HI_IDLE;
            b_next     = 1'b1;
            press_next = 1'b1;
            cnt_next   = '0;
          end else begin
            state_next = LO_WAIT;
            cnt_next   = CNT_ONE;
          end
        end
      end
      LO_WAIT: begin
        if (!s) begin
          state_next = LO_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HI_IDLE;
          b_next     = 1'b1;
          press_next = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HI_IDLE: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_next   = LO_IDLE;
            b_next       = 1'b0;
            release_next = 1'b1;
            cnt_next     = '0;
          end else begin
            state_next = HI_WAIT;
            cnt_next   = CNT_ONE;
          end
        end
      end
      HI_WAIT: begin
        if (s) begin
          state_next = HI_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = LO_IDLE;
          b_next       = 1'b0;
          release_next = 1'b1;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = LO_IDLE;
        cnt_next   = '0;
      end
    endcase

`ifdef BTN_COND_STUCK_EN
    // The stuck timeout takes priority over a release accepted on the same
    // edge: the level drops silently and no pulse is produced.
    if (state_reg == HI_IDLE || state_reg == HI_WAIT) begin
      if (stuck_cnt_reg == SCNT_LAST) begin
        stuck_cnt_next = SCNT_MAX;
        stuck_next     = 1'b1;
        b_next         = 1'b0;
        state_next     = LO_IDLE;
        cnt_next       = '0;
        press_next     = 1'b0;
        release_next   = 1'b0;
      end else begin
        stuck_cnt_next = stuck_cnt_reg + SCNT_W'(1);
      end
    end
`endif
  end

  assign b_out         = b_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;

endmodule

// File: tb/tb_btn_cond.sv
// -----------------------------------------------------------------------------
// tb_btn_cond
// Drives two btn_cond instances (DEBOUNCE_CYCLES 4 and 1, STUCK_CYCLES 16)
// from the same button and reset. Every cycle both are compared against a
// reference that decides each edge from the window of recent synchronized
// samples and the time since the last accepted rise.
// -----------------------------------------------------------------------------
module tb_btn_cond;

  localparam int D0 = 4;
  localparam int D1 = 1;
  localparam int SC = 16;
`ifdef BTN_COND_STUCK_EN
  localparam logic STUCK_ON = 1'b1;
`else
  localparam logic STUCK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic clear;
  logic btn_raw;
  logic b0, p0, r0, st0;
  logic b1, p1, r1, st1;

  always #5 clk = ~clk;

  btn_cond #(.DEBOUNCE_CYCLES(D0), .STUCK_CYCLES(SC)) dut0 (
    .clk           (clk),
    .clear         (clear),
    .btn_raw       (btn_raw),
    .b_out         (b0),
    .press_pulse   (p0),
    .release_pulse (r0),
    .stuck         (st0)
  );

  btn_cond #(.DEBOUNCE_CYCLES(D1), .STUCK_CYCLES(SC)) dut1 (
    .clk           (clk),
    .clear         (clear),
    .btn_raw       (btn_raw),
    .b_out         (b1),
    .press_pulse   (p1),
    .release_pulse (r1),
    .stuck         (st1)
  );

  // Reference state: raw pipeline, recent FSM samples (newest first, -1 =
  // not counted), and the expected outputs.
  int   dd[2] = '{D0, D1};
  logic m_r1[2];
  logic m_s[2];
  int   hist[2][8];
  logic m_b[2], m_p[2], m_rl[2], m_st[2];
  int   rise_edge[2];
  int   edge_no;
  int   n_assert;
  int   n_fail;

  function automatic bit window_all(input int i, input int v);
    for (int j = 0; j < dd[i]; j++)
      if (hist[i][j] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic forget(input int i);
    for (int j = 0; j < 8; j++) hist[i][j] = -1;
  endtask

  task automatic model_edge(input int i);
    int smp;
    if (!clear) begin
      m_r1[i] = 1'b0; m_s[i] = 1'b0;
      m_b[i] = 1'b0; m_p[i] = 1'b0; m_rl[i] = 1'b0; m_st[i] = 1'b0;
      forget(i);
    end else begin
      smp = int'(m_s[i]);
      m_s[i]  = m_r1[i];
      m_r1[i] = btn_raw;
      for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = smp;
      m_p[i] = 1'b0; m_rl[i] = 1'b0;
      if (m_st[i]) begin
        if (window_all(i, 0)) begin
          m_st[i] = 1'b0;
          forget(i);
        end
      end else if (STUCK_ON && m_b[i] && (edge_no - rise_edge[i] == SC)) begin
        m_st[i] = 1'b1;
        m_b[i]  = 1'b0;
        forget(i);
      end else if (window_all(i, m_b[i] ? 0 : 1)) begin
        m_b[i] = ~m_b[i];
        if (m_b[i]) begin
          m_p[i] = 1'b1;
          rise_edge[i] = edge_no;
        end else begin
          m_rl[i] = 1'b1;
        end
        forget(i);
      end
    end
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_no, got, exp);
    end
  endtask

  // One falling edge with the given inputs, then a full compare on the
  // following rising edge.
  task automatic tick(input logic raw, input logic clr);
    btn_raw = raw;
    clear   = clr;
    @(negedge clk);
    edge_no++;
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    chk("b_out_d4", b0, m_b[0]);
    chk("press_d4", p0, m_p[0]);
    chk("release_d4", r0, m_rl[0]);
    chk("stuck_d4", st0, m_st[0]);
    chk("b_out_d1", b1, m_b[1]);
    chk("press_d1", p1, m_p[1]);
    chk("release_d1", r1, m_rl[1]);
    chk("stuck_d1", st1, m_st[1]);
  endtask

  initial begin
    int len;
    logic lvl;
    logic clr;
    n_assert = 0;
    n_fail   = 0;
    edge_no  = 0;
    btn_raw  = 1'b0;
    clear    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_r1[i] = 1'b0; m_s[i] = 1'b0; m_b[i] = 1'b0; m_p[i] = 1'b0;
      m_rl[i] = 1'b0; m_st[i] = 1'b0; rise_edge[i] = 0;
      forget(i);
    end
    @(posedge clk);

    // Reset state
    repeat (3) tick(1'b0, 1'b0);
    chk("reset_b_out", b0, 1'b0);
    chk("reset_press", p0, 1'b0);
    chk("reset_release", r0, 1'b0);
    chk("reset_stuck", st0, 1'b0);
    repeat (4) tick(1'b0, 1'b1);

    // Clean press: rise after edge k+5 (k+2 for the single-sample instance)
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 1'b1);
      if (i == 2) chk("d1_before_rise", b1, 1'b0);
      if (i == 3) chk("d1_rise", b1, 1'b1);
      if (i == 5) chk("press_before_rise", b0, 1'b0);
      if (i == 6) chk("press_rise", b0, 1'b1);
      if (i == 6) chk("press_pulse_on", p0, 1'b1);
      if (i == 7) chk("press_pulse_off", p0, 1'b0);
    end
    // Clean release: mirror latency
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0, 1'b1);
      if (i == 5) chk("release_before_fall", b0, 1'b1);
      if (i == 6) chk("release_fall", b0, 1'b0);
      if (i == 6) chk("release_pulse_on", r0, 1'b1);
      if (i == 7) chk("release_pulse_off", r0, 1'b0);
    end

    // Glitch of 3 samples, then 1-1-1-0-1-1-1-1
    repeat (3) tick(1'b1, 1'b1);
    repeat (8) tick(1'b0, 1'b1);
    chk("glitch_no_rise", b0, 1'b0);
    repeat (3) tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    repeat (10) tick(1'b1, 1'b1);
    chk("glitch_then_rise", b0, 1'b1);
    repeat (10) tick(1'b0, 1'b1);

    // Reset mid-debounce while the button stays held
    repeat (5) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    chk("midreset_b_out", b0, 1'b0);
    chk("midreset_b_out_d1", b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b1);
      if (i == 5) chk("midreset_before_rise", b0, 1'b0);
      if (i == 6) chk("midreset_rise", b0, 1'b1);
    end
    repeat (10) tick(1'b0, 1'b1);

    // Long hold: stuck behaviour depends on the build option
    repeat (40) tick(1'b1, 1'b1);
    chk("hold_stuck", st0, STUCK_ON);
    chk("hold_b_out", b0, ~STUCK_ON);
    repeat (8) tick(1'b0, 1'b1);
    chk("hold_release_stuck", st0, 1'b0);
    repeat (8) tick(1'b1, 1'b1);
    chk("after_stuck_press", b0, 1'b1);
    repeat (8) tick(1'b0, 1'b1);

    // Random segments with occasional resets and long holds
    for (int seg = 0; seg < 400; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 30))
                                        : int'($urandom_range(1, 7));
      for (int c = 0; c < len; c++) begin
        clr = ($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1;
        tick(lvl, clr);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_cond.md
# btn_cond

Button input conditioner sitting directly upstream of the digital lock FSM. It synchronizes and debounces a raw pushbutton and drives the lock's serial `b_in` input with a clean level. It also emits one-cycle press and release pulses. Clocking and reset match the lock: all state updates on the falling edge of `clk`, with the same active-low `clear`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical synchronized samples required to accept a level change; legal range 1..255.
- `STUCK_CYCLES`, default 1024: debounced-high duration that flags a stuck button; used only with the stuck feature.
- `clk`  in  1  single clock; every flop updates on the falling edge.
- `clear`  in  1  reset; synchronous and active-low.
- `btn_raw`  in  1  asynchronous raw button, 1 = pressed.
- `b_out`  out  1  debounced level, wired to the lock's `b_in`.
- `press_pulse`  out  1  high for one cycle when `b_out` rises.
- `release_pulse`  out  1  high for one cycle when `b_out` falls.
- `stuck`  out  1  stuck-button flag; tied 0 when the feature is compiled out.

## Operation
- **Synchronizer.** Two flops clocked on the falling edge; `s` is the second-stage output.
- **States:** LO_IDLE, LO_WAIT, HI_IDLE, HI_WAIT.
- **Debounce counter.** Width `$clog2(DEBOUNCE_CYCLES+1)`. It counts consecutive samples of `s` at the candidate level.
- **LO_IDLE:**
  - `s`=1 → LO_WAIT, cnt=1.
  - If DEBOUNCE_CYCLES=1, go straight to HI_IDLE instead.
- **LO_WAIT:**
  - `s`=0 → LO_IDLE, cnt=0. Any single opposite sample restarts the count.
  - `s`=1 and cnt=DEBOUNCE_CYCLES-1 → HI_IDLE, `b_out`←1, `press_pulse`←1.
  - Otherwise cnt+1.
- **HI_IDLE / HI_WAIT:** mirror of the low side with `s`=0. Acceptance gives `b_out`←0 and `release_pulse`←1.
- Pulses are registered and deassert on the next edge. Press and release can never assert on the same edge.
- **Reset.** `clear`=0 at an edge sets all flops as follows; this overrides every other event on that edge, including mid-debounce:
  - synchronizer flops 0
  - state LO_IDLE
  - cnt 0
  - `b_out` 0
  - `press_pulse` 0, `release_pulse` 0
  - `stuck` 0, stuck counter 0

## Timing
- Define edge k as the first falling edge at which `btn_raw` is stably high.
- Sample sequence: `s`=1 after edge k+1; the FSM's n-th sample of `s` is at edge k+1+n.
- `b_out` rises after edge k+1+DEBOUNCE_CYCLES, i.e. k+5 at the default. Release latency is identical.
- A button held through reset is treated as a fresh press. The first active edge after `clear` goes high is edge 0; `b_out` rises after edge 1+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES samples produces no change on `b_out` and no pulses.
- Counters never wrap:
  - the debounce counter is bounded by the acceptance compare;
  - the stuck counter saturates at STUCK_CYCLES.

## Configuration
- Macro: `BTN_COND_STUCK_EN`.
- **Defined:**
  - A stuck counter (width `$clog2(STUCK_CYCLES+1)`) increments each edge in HI_IDLE/HI_WAIT and clears in the LO states.
  - When it reaches STUCK_CYCLES: `stuck`←1, `b_out`←0, FSM→LO_IDLE, no `release_pulse`.
  - `stuck` then stays high and the FSM stays in LO_IDLE until `s` has been 0 for DEBOUNCE_CYCLES consecutive samples.
  - At that point `stuck` clears on the same edge, with no pulse.
  - A new press is then debounced normally.
- **Undefined:**
  - No stuck counter is built.
  - `stuck` is driven constant 0.
  - A held button keeps `b_out`=1 indefinitely.

## Structure
- Shared package `dlock_pkg` holds:
  - the `btn_state_t` enum (LO_IDLE, LO_WAIT, HI_IDLE, HI_WAIT);
  - the default constants `DLOCK_DEBOUNCE_DEF`=4 and `DLOCK_STUCK_DEF`=1024.
- One sub-module, `sync_2ff`: a 1-bit, two-flop, falling-edge synchronizer with synchronous active-low `clear`.
- FSM, counters and pulse registers live in `btn_cond`.

## Test plan
Benches run with DEBOUNCE_CYCLES=4 and STUCK_CYCLES=16.
- **Clean press.** `btn_raw` 0→1 before edge 10, held → `b_out`=1 after edge 15; `press_pulse` high only for the cycle following edge 15; release 30 edges later gives the mirror result.
- **Glitch.** `btn_raw` high for 3 edges then low → `b_out` stays 0, no pulses. Then 1-1-1-0-1-1-1-1 on `s` → single rise, after the 4th consecutive 1.
- **Reset mid-debounce.** `clear`=0 for one edge while in LO_WAIT with cnt=3 → all outputs 0, cnt=0. `btn_raw` still held gives a rise after edge 5 counted from `clear` high.
- **DEBOUNCE_CYCLES=1.** Raw rise before edge k → `b_out`=1 after edge k+2.
- **Stuck, `BTN_COND_STUCK_EN` defined.** Hold 40 edges → `stuck`=1 and `b_out`=0, 16 edges after `b_out` rose, with no `release_pulse`. Release → `stuck`=0 after 4 low samples; next press gives a normal rise.
- **Stuck, `BTN_COND_STUCK_EN` undefined.** Same hold → `stuck`=0 throughout and `b_out`=1 for the whole hold.
